ps2_key_ctrl: RTL
=================

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000; idle cycles of clk_i inside a frame before the partial frame is aborted.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; number of key-event entries (power of two, at least 2).
REQ-003 SHALL have port clk_i, input, 1 bit; the single system clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit; asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk_i, input, 1 bit; raw PS/2 clock, asynchronous.
REQ-006 SHALL have port ps2_data_i, input, 1 bit; raw PS/2 data, asynchronous.
REQ-007 SHALL have port key_valid_o, output, 1 bit; FIFO head holds an event.
REQ-008 SHALL have port key_ready_i, input, 1 bit; consumer pops the head when key_valid_o && key_ready_i.
REQ-009 SHALL have port key_code_o, output, 4 bits; head event key index.
REQ-010 SHALL have port key_release_o, output, 1 bit; head event is a break (release).
REQ-011 SHALL have port key_ext_o, output, 1 bit; head event carried an E0 prefix.
REQ-012 SHALL have port digit_o, output, 4 bits; index of the last make (press) event accepted into the FIFO.
REQ-013 SHALL have port err_o, output, 1 bit; one-cycle pulse on a parity, stop or timeout error.
REQ-014 SHALL have port overflow_o, output, 1 bit; sticky flag, set when an event is dropped because the FIFO is full.

Function
REQ-015 ps2_clk_i and ps2_data_i SHALL each pass through a 2-flop synchronizer; a falling edge is synchronized clk 1->0.
REQ-016 Frame SHALL be 11 bits sampled on falling edges: start 0, 8 data bits LSB-first, odd parity, stop 1.
REQ-017 A start bit of 1 SHALL be ignored silently and the bit counter SHALL stay at 0.
REQ-018 Bad parity or stop=0 SHALL discard the byte, pulse err_o, and return the decoder FSM to IDLE.
REQ-019 If the bit counter is non-zero and TIMEOUT_CYCLES cycles pass with no falling edge, the counter SHALL clear to 0 and err_o SHALL pulse.
REQ-020 The decoder FSM SHALL have states IDLE, EXT, BRK and EXT_BRK.
REQ-021 Decoder transitions SHALL be:
- IDLE + E0 -> EXT; IDLE + F0 -> BRK.
- EXT + F0 -> EXT_BRK; EXT + E0 -> EXT.
- BRK + F0 -> BRK.
- Any other byte -> emit an event, then IDLE.
REQ-022 An event SHALL carry release=1 in BRK or EXT_BRK and ext=1 in EXT or EXT_BRK.
REQ-023 Key index map SHALL be 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9, 4E->10, 55->11.
REQ-024 An unmapped code SHALL produce no event, return the FSM to IDLE, and SHALL NOT pulse err_o.
REQ-025 For a stop-bit falling edge detected in cycle N, the decoder SHALL update at N+1, and key_valid_o SHALL be high from N+2 if the FIFO was empty.
REQ-026 The FIFO SHALL be first-in first-out; outputs SHALL reflect the head combinationally from registered storage.
REQ-027 A push SHALL be accepted when not full, or when full with a pop in the same cycle.
REQ-028 A push with the FIFO full and no pop SHALL drop the event and set overflow_o.
REQ-029 Pop SHALL occur only when key_valid_o && key_ready_i; a pop on an empty FIFO SHALL be a no-op.
REQ-030 digit_o SHALL update only on an accepted make event; release, extended-release and dropped events SHALL leave it unchanged.

Reset
REQ-031 On rst_ni=0, asynchronously:
- synchronizers reset to 1.
- bit counter, timeout counter and FIFO pointers clear to 0.
- FSM goes to IDLE.
- key_valid_o, key_code_o, key_release_o, key_ext_o, digit_o, err_o and overflow_o go to 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL decode normally.

Structure
REQ-033 A shared package ps2_pkg SHALL hold the prefix constants (E0, F0), the FSM state enum, and the scan-code-to-index map function.
REQ-034 The frame receiver (synchronizer, edge detect, shift, parity, timeout) SHALL be the sub-module ps2_frame_rx, with outputs byte/valid/err.

Verification
REQ-035 Frame 16 with parity 0 and ready=1 -> one event {code 1, rel 0, ext 0}; digit_o=1; key_valid_o high exactly at N+2.
REQ-036 Bytes F0,16 -> event {1, rel 1, ext 0}; digit_o unchanged. Bytes E0,F0,45 -> event {0, rel 1, ext 1}.
REQ-037 Byte 16 with parity flipped -> err_o one-cycle pulse, no event; a following good 1E -> event code 2.
REQ-038 Feed 4 clock edges, then idle TIMEOUT_CYCLES -> err_o pulses; a following good 26 -> event code 3.
REQ-039 ready=0 with 5 make events 1..5 (DEPTH 4) -> overflow_o=1; events 1-4 pop in order; digit_o=4.
REQ-040 Reset pulse during bit 5 of a frame -> all outputs 0; the next full frame 46 -> event code 9.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: prefix bytes, decoder states, event layout
// and the scan-code to key-index map.
package ps2_pkg;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } dec_state_e;

    typedef struct packed {
        logic       rel;
        logic       ext;
        logic [3:0] code;
    } key_event_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_map_t;

    function automatic key_map_t map_scan(input logic [7:0] scan);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = '0;
        case (scan)
            8'h45:   m.idx = 4'd0;
            8'h16:   m.idx = 4'd1;
            8'h1E:   m.idx = 4'd2;
            8'h26:   m.idx = 4'd3;
            8'h25:   m.idx = 4'd4;
            8'h2E:   m.idx = 4'd5;
            8'h36:   m.idx = 4'd6;
            8'h3D:   m.idx = 4'd7;
            8'h3E:   m.idx = 4'd8;
            8'h46:   m.idx = 4'd9;
            8'h4E:   m.idx = 4'd10;
            8'h55:   m.idx = 4'd11;
            default: m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, samples 11-bit frames on
// falling clock edges, checks odd parity and stop bit, aborts stalled frames.
module ps2_frame_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o
);
    import ps2_pkg::*;

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          data_s;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity;
    logic [TW-1:0] idle_cnt;

    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_sync[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            clk_prev  <= clk_sync[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            idle_cnt <= '0;
            byte_o   <= '0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                case (bit_cnt)
                    // a start bit of 1 is noise: stay waiting for a real start
                    4'd0: if (!data_s) bit_cnt <= 4'd1;
                    4'd9: begin
                        parity  <= data_s;
                        bit_cnt <= 4'd10;
                    end
                    4'd10: begin
                        bit_cnt <= '0;
                        if (data_s && ((^shift) ^ parity)) begin
                            byte_o  <= shift;
                            valid_o <= 1'b1;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    default: begin
                        shift   <= {data_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                endcase
            end else if (bit_cnt != '0) begin
                if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                    err_o    <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key controller: decodes E0/F0 prefixed scan codes into key events and
// queues them in a small FIFO for a ready/valid consumer.
module ps2_key_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       key_valid_o,
    input  logic       key_ready_i,
    output logic [3:0] key_code_o,
    output logic       key_release_o,
    output logic       key_ext_o,
    output logic [3:0] digit_o,
    output logic       err_o,
    output logic       overflow_o
);
    import ps2_pkg::*;

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .byte_o     (rx_byte),
        .valid_o    (rx_valid),
        .err_o      (rx_err)
    );

    assign err_o = rx_err;

    dec_state_e state, state_nxt;
    key_map_t   hit;
    key_event_t ev;
    logic       push;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        ev        = '0;
        hit       = map_scan(rx_byte);
        if (rx_err) begin
            state_nxt = IDLE;
        end else if (rx_valid) begin
            state_nxt = IDLE;
            case (state)
                IDLE: begin
                    if (rx_byte == CODE_EXT)      state_nxt = EXT;
                    else if (rx_byte == CODE_BRK) state_nxt = BRK;
                end
                EXT: begin
                    if (rx_byte == CODE_BRK)      state_nxt = EXT_BRK;
                    else if (rx_byte == CODE_EXT) state_nxt = EXT;
                end
                BRK: if (rx_byte == CODE_BRK) state_nxt = BRK;
                default: ;
            endcase
            // prefixes never map, so a mapped byte always terminates the sequence
            if (state_nxt == IDLE && hit.hit) begin
                push    = 1'b1;
                ev.rel  = (state inside {BRK, EXT_BRK});
                ev.ext  = (state inside {EXT, EXT_BRK});
                ev.code = hit.idx;
            end
        end
    end

    key_event_t  mem [FIFO_DEPTH];
    key_event_t  head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, pop, accept;

    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign key_valid_o = (wr_ptr != rd_ptr);
    assign pop         = key_valid_o && key_ready_i;
    assign accept      = push && (!full || pop);
    assign head        = key_valid_o ? mem[rd_ptr[AW-1:0]] : '0;

    assign key_code_o    = head.code;
    assign key_release_o = head.rel;
    assign key_ext_o     = head.ext;

    always_ff @(posedge clk_i) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= ev;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            digit_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (accept && !ev.rel) digit_o <= ev.code;
            if (push && !accept)   overflow_o <= 1'b1;
        end
    end

endmodule
